// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory request multiplexer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_mux_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i searching
// ptr_i, ptr_i+1, ... and wrapping at N_PORTS.
module rr_picker #(
    parameter int N_PORTS = 4,
    parameter int PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   grant_o,
    output logic               any_o
);

    logic [PTR_W:0]   sum_w    [N_PORTS];
    logic [PTR_W-1:0] cand_idx [N_PORTS];
    logic             cand_vld [N_PORTS];

    // Candidate gi is the channel gi positions after ptr, reduced mod N_PORTS.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cand
            assign sum_w[gi]    = {1'b0, ptr_i} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum_w[gi] >= (PTR_W+1)'(N_PORTS))
                                ? PTR_W'(sum_w[gi] - (PTR_W+1)'(N_PORTS))
                                : sum_w[gi][PTR_W-1:0];
            assign cand_vld[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest one wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (cand_vld[i]) begin
                grant_o = cand_idx[i];
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb_mux.sv
// N-channel memory request multiplexer: round-robin grant, one transaction
// outstanding, valid/ready downstream and one-hot response routing back.
module mem_arb_mux
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_PORTS-1:0]                   req_valid_i,
    input  logic [N_PORTS-1:0]                   req_wen_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    output logic [N_PORTS-1:0]                   req_ready_o,
    output logic [N_PORTS-1:0]                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]                resp_rdata_o,
    output logic                                 mem_valid_o,
    output logic                                 mem_wen_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_ready_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        ptr_reg, ptr_next;
    logic [PTR_W-1:0]        grant_reg, grant_next;
    logic                    wen_reg, wen_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [N_PORTS-1:0]      resp_valid_reg, resp_valid_next;
    logic [DATA_WIDTH-1:0]   resp_rdata_reg, resp_rdata_next;

    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    complete;

    rr_picker #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_reg),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            wen_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            resp_valid_reg <= '0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            grant_reg      <= grant_next;
            wen_reg        <= wen_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        grant_next      = grant_reg;
        wen_next        = wen_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        resp_valid_next = '0;
        resp_rdata_next = resp_rdata_reg;
        complete        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = REQ;
                    grant_next = pick_idx;
                    wen_next   = req_wen_i[pick_idx];
                    addr_next  = req_addr_i[pick_idx];
                    wdata_next = req_wdata_i[pick_idx];
                end
            end
            REQ: begin
                // An rvalid alongside the accept finishes the transaction at once.
                if (mem_ready_i) begin
                    if (mem_rvalid_i) complete = 1'b1;
                    else              state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) complete = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (complete) begin
            state_next                 = IDLE;
            resp_valid_next[grant_reg] = 1'b1;
            resp_rdata_next            = mem_rdata_i;
            ptr_next = (grant_reg == PTR_W'(N_PORTS - 1)) ? '0 : grant_reg + PTR_W'(1);
        end
    end

    // Grant pulse is combinational, so it is also held off while reset is low.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state_reg == IDLE && pick_any) begin
            req_ready_o[pick_idx] = 1'b1;
        end
    end

    assign mem_valid_o  = (state_reg == REQ);
    assign mem_wen_o    = wen_reg;
    assign mem_addr_o   = addr_reg;
    assign mem_wdata_o  = wdata_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_rdata_o = resp_rdata_reg;

endmodule
